mem_rf_lemma_mp: RTL
====================

# mem_rf_lemma_mp

Parametrised multi-port, byte-organised register-file memory with a word-addressed write port and an integrated read-consistency monitor. It is the next generation of the RISC-V ILA lemma-check memory model. It adds byte-strobed writes, registered reads on a configurable number of ports, and optional write-to-read bypass. A cycle-counter-gated checker flags any two read ports that return different data for the same address. It sits beside the register-file/memory model in ILAVerif lemma-check harnesses and is also usable as a simulation-checked memory.

## Interface
- WORD_ADDR_W, 30: width of word addresses; byte address is {addr, 2'b00}.
- MEM_BYTES, 512: storage size in bytes; power of two, ≥ 8.
- NUM_RD, 2: number of read ports, 2..8.
- BYPASS, 1: 1 = same-cycle write is visible to reads; 0 = reads see pre-write contents.
- CHECK_AT, 3: counter value (0..15) on which read requests are sampled for checking.

Ports (all synchronous to clock):
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low. 0 at a rising edge resets state.
- wr_en  in  1  write request.
- wr_addr  in  WORD_ADDR_W  word address of write.
- wr_strb  in  4  byte-lane enables. Bit k writes byte lane k (wr_data[8k+7:8k]).
- wr_data  in  32  write data, little-endian lanes.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*WORD_ADDR_W  packed word addresses; port i at [i*WORD_ADDR_W +: WORD_ADDR_W].
- rd_data  out  NUM_RD*32  packed read data; port i at [i*32 +: 32].
- rd_valid  out  NUM_RD  per-port data-valid, one cycle after rd_en.
- chk_cnt  out  4  free-running check counter.
- chk_fail  out  1  sticky mismatch flag.
- chk_fail_cnt  out  8  saturating count of failing check cycles.

## Operation
- Storage is MEM_BYTES bytes. Byte index = ({addr,2'b00}) mod MEM_BYTES, i.e. the low log2(MEM_BYTES) bits. Higher address bits are ignored (aliasing is intended).
- A word comprises bytes idx..idx+3. Lane k maps to byte idx+k, and idx is always 4-aligned, so there is no intra-word wrap.
- Storage contents are not reset. They hold their value unless written.
- Write: when wr_en=1 and reset=1, each lane k with wr_strb[k]=1 is updated. wr_strb=0 with wr_en=1 is a no-op.
- Writes are ignored during reset.
- Read, port i: when rd_en[i]=1, rd_data[i] is loaded at the next edge with the addressed word, and rd_valid[i] is set to 1.
- When rd_en[i]=0, rd_data[i] holds and rd_valid[i] is set to 0.
- Read/write collision (same word, same cycle):
  - BYPASS=1: strobed lanes return wr_data; unstrobed lanes return stored bytes.
  - BYPASS=0: all lanes return the stored (old) bytes.
- Multiple ports reading the same word in the same cycle are legal and must return identical data.
- Checker:
  - chk_cnt increments by 1 every non-reset cycle and wraps 15→0.
  - When chk_cnt==CHECK_AT, a one-cycle check_pending flag is set. The read addresses and rd_en are captured at that time.
  - On the following cycle, consider every pair i<j with both captured rd_en set and equal captured addresses. If any such pair has rd_data[i]≠rd_data[j], then:
    - chk_fail is set to 1 and stays 1 until reset.
    - chk_fail_cnt increments by 1, once per cycle regardless of how many pairs fail, saturating at 255.
- Reset values: rd_data=0, rd_valid=0, chk_cnt=0, chk_fail=0, chk_fail_cnt=0. check_pending and captured request state are cleared.

## Timing
- Read latency: 1 cycle. Request at edge N produces rd_data/rd_valid at edge N+1.
- Write latency: a write at edge N is visible to reads issued in cycle N+1. It is also visible in cycle N only if BYPASS=1.
- Checker latency: requests sampled in the chk_cnt==CHECK_AT cycle. chk_fail rises at the edge ending the following cycle, i.e. 2 edges after the request edge.
- Reset mid-operation:
  - Takes effect at the next edge.
  - In-flight reads are discarded (rd_valid=0) and a pending check is cancelled.
  - Memory contents are preserved.
- First check after reset occurs when chk_cnt first equals CHECK_AT, i.e. CHECK_AT cycles after reset deasserts.
- Checker is combinational on registered rd_data only. No read-port input feeds the compare in the same cycle.

## Test plan
- Write word 0x0000_0010 = 0xDEADBEEF (strb 0xF). Next cycle, read on ports 0 and 1 → both rd_data=0xDEADBEEF with rd_valid=1 one cycle later.
- Partial write: strb=0b0101 with data 0x11223344 over 0xDEADBEEF → readback 0xDE22BE44.
- Aliasing: with MEM_BYTES=512, write addr 0x80 and read addr 0x00 → returns the written word.
- Collision on the same word with strb=0b0011:
  - BYPASS=1 → new low half, old high half.
  - BYPASS=0 → fully old word.
- Checker: both ports read the same address at chk_cnt=3 → chk_fail stays 0. Forcing a data mismatch on one port (bench force on rd_data[1]) → chk_fail=1 and chk_fail_cnt=1. Repeating the mismatch 300 times → chk_fail_cnt saturates at 255.
- Assert reset (0) for one cycle mid-read → rd_valid=0, chk_cnt=0, chk_fail=0; the previously written word still reads back unchanged afterwards.

Source files
------------

// File: rtl/mem_rf_lemma_mp.sv
// Byte-organised multi-port register-file memory with strobed writes,
// registered reads and a counter-gated read-consistency checker.
module mem_rf_lemma_mp #(
  parameter int WORD_ADDR_W = 30,
  parameter int MEM_BYTES   = 512,
  parameter int NUM_RD      = 2,
  parameter int BYPASS      = 1,
  parameter int CHECK_AT    = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [WORD_ADDR_W-1:0]        wr_addr,
  input  logic [3:0]                    wr_strb,
  input  logic [31:0]                   wr_data,
  input  logic [NUM_RD-1:0]             rd_en,
  input  logic [NUM_RD*WORD_ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*32-1:0]          rd_data,
  output logic [NUM_RD-1:0]             rd_valid,
  output logic [3:0]                    chk_cnt,
  output logic                          chk_fail,
  output logic [7:0]                    chk_fail_cnt
);

  localparam int NWORDS = MEM_BYTES / 4;
  localparam int WIDX_W = $clog2(NWORDS);
  localparam int AW     = WORD_ADDR_W;

  logic [3:0][7:0] mem_q [NWORDS];

  logic [NUM_RD*32-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]    rd_valid_q, rd_valid_d;
  logic [3:0]           chk_cnt_q, chk_cnt_d;
  logic                 pend_q, pend_d;
  logic [NUM_RD-1:0]    cap_en_q, cap_en_d;
  logic [NUM_RD*AW-1:0] cap_addr_q, cap_addr_d;
  logic                 fail_q, fail_d;
  logic [7:0]           fcnt_q, fcnt_d;

  logic              wr_act;
  logic [WIDX_W-1:0] wr_widx;
  logic [WIDX_W-1:0] rd_widx [NUM_RD];
  logic [31:0]       rd_word [NUM_RD];
  logic              mis;
  logic              unused_hi;

  // Only the low word-index bits select storage; the rest alias.
  assign wr_act    = reset & wr_en;
  assign wr_widx   = wr_addr[WIDX_W-1:0];
  assign unused_hi = ^wr_addr[AW-1:WIDX_W];

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_widx[i] = rd_addr[i*AW +: WIDX_W];
    end
  end

  always_comb begin
    rd_word = '{default: '0};
    for (int i = 0; i < NUM_RD; i++) begin
      for (int k = 0; k < 4; k++) begin
        rd_word[i][8*k +: 8] = mem_q[rd_widx[i]][k];
        if (BYPASS != 0 && wr_act && wr_strb[k] &&
            rd_widx[i] == wr_widx) begin
          rd_word[i][8*k +: 8] = wr_data[8*k +: 8];
        end
      end
    end
  end

  // Compare only registered data against the requests captured last cycle.
  always_comb begin
    mis = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int j = i + 1; j < NUM_RD; j++) begin
        if (cap_en_q[i] && cap_en_q[j] &&
            cap_addr_q[i*AW +: AW] == cap_addr_q[j*AW +: AW] &&
            rd_data_q[i*32 +: 32] != rd_data_q[j*32 +: 32]) begin
          mis = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_en[i]) begin
        rd_data_d[i*32 +: 32] = rd_word[i];
      end
    end
    chk_cnt_d  = chk_cnt_q + 4'd1;
    pend_d     = (chk_cnt_q == 4'(CHECK_AT));
    cap_en_d   = cap_en_q;
    cap_addr_d = cap_addr_q;
    if (pend_d) begin
      cap_en_d   = rd_en;
      cap_addr_d = rd_addr;
    end
    fail_d = fail_q | (pend_q & mis);
    fcnt_d = fcnt_q;
    if (pend_q && mis && fcnt_q != 8'hFF) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_act) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_strb[k]) begin
          mem_q[wr_widx][k] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      chk_cnt_q  <= '0;
      pend_q     <= 1'b0;
      cap_en_q   <= '0;
      cap_addr_q <= '0;
      fail_q     <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      chk_cnt_q  <= chk_cnt_d;
      pend_q     <= pend_d;
      cap_en_q   <= cap_en_d;
      cap_addr_q <= cap_addr_d;
      fail_q     <= fail_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign chk_cnt      = chk_cnt_q;
  assign chk_fail     = fail_q;
  assign chk_fail_cnt = fcnt_q;

endmodule
